prog_sequencer: RTL and testbench

Program-flow controller for the 8-bit core.
- Owns the program counter and drives the program-memory address.
- Consumes the decoder's flow-control strobes (rstPC, cePC, wrJumpAdr, jumpAdr) plus new CALL/RET strobes, and keeps a hardware return-address stack.
- Adds a debug halt/single-step handshake.
- Issues execEn, which gates all datapath write enables (register file, accumulator, data memory, ports) so that a halted or faulted core commits nothing.

---
 rtl/prog_sequencer_pkg.sv | 21 ++
 rtl/prog_sequencer_if.sv | 31 +++
 rtl/prog_sequencer_stack.sv | 55 +++++
 rtl/prog_sequencer.sv | 138 +++++++++++++
 tb/tb_prog_sequencer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared types and defaults for the program-flow sequencer.
package prog_sequencer_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        STEP  = 2'd2,
        FAULT = 2'd3
    } seq_state_t;

    localparam int SEQ_PROG_MEM_LENGTH = 8;
    localparam int SEQ_STACK_DEPTH     = 8;
    localparam int SEQ_RESET_VEC       = 0;

    // Width of a stack level count: must represent 0..depth inclusive.
    function automatic int stack_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Decoder/debugger-facing bundle of the program-flow sequencer.
interface prog_sequencer_if #(
    parameter int PML = 8,
    parameter int LW  = 4
);
    logic           rstPC;
    logic           cePC;
    logic           wrJumpAdr;
    logic [PML-1:0] jumpAdr;
    logic           call;
    logic           ret;
    logic           dbgHalt;
    logic           dbgStep;
    logic [PML-1:0] adrProgMem;
    logic           execEn;
    logic           halted;
    logic           stackFault;
    logic [LW-1:0]  stackLevel;

    // Decoder / debug side: drives strobes, observes the sequencer.
    modport master (
        output rstPC, cePC, wrJumpAdr, jumpAdr, call, ret, dbgHalt, dbgStep,
        input  adrProgMem, execEn, halted, stackFault, stackLevel
    );

    // Sequencer side.
    modport slave (
        input  rstPC, cePC, wrJumpAdr, jumpAdr, call, ret, dbgHalt, dbgStep,
        output adrProgMem, execEn, halted, stackFault, stackLevel
    );
endinterface

// File: rtl/prog_sequencer_stack.sv
// Return-address LIFO: small register array, level counter doubles as pointer.
module seq_stack
    import prog_sequencer_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          push,
    input  logic                          pop,
    input  logic [W-1:0]                  din,
    output logic [W-1:0]                  dout,
    output logic [stack_ptr_w(DEPTH)-1:0] level,
    output logic                          full,
    output logic                          empty
);
    localparam int LW  = stack_ptr_w(DEPTH);
    localparam int PTR = $clog2(DEPTH);

    logic [W-1:0]   mem_q [DEPTH];
    logic [LW-1:0]  level_q;
    logic [PTR-1:0] wr_idx;
    logic [PTR-1:0] rd_idx;

    // The low bits of the level are the next free slot; top sits one below.
    // When full the low bits wrap to 0, so the top still lands on DEPTH-1.
    assign wr_idx = level_q[PTR-1:0];
    assign rd_idx = level_q[PTR-1:0] - PTR'(1);

    assign dout  = mem_q[rd_idx];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // Entry storage; entries are not reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

    // Occupancy counter; clear and reset both empty the stack.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            level_q <= '0;
        end else if (push && !full) begin
            level_q <= level_q + LW'(1);
        end else if (pop && !empty) begin
            level_q <= level_q - LW'(1);
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Program counter, return stack and debug halt/step control for the 8-bit core.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int prog_mem_length = SEQ_PROG_MEM_LENGTH,
    parameter int STACK_DEPTH     = SEQ_STACK_DEPTH,
    parameter int RESET_VEC       = SEQ_RESET_VEC
) (
    input  logic          clk,
    input  logic          rst,
    prog_sequencer_if.slave bus
);
    localparam int PW = prog_mem_length;
    localparam int LW = stack_ptr_w(STACK_DEPTH);
    localparam logic [PW-1:0] RV = PW'(RESET_VEC);

    seq_state_t    state_q;
    logic [PW-1:0] pc_q;
    logic [PW-1:0] pc_d;
    logic          exec_en_q;
    logic          halted_q;
    logic          fault_q;

    logic          stk_clr;
    logic          stk_push;
    logic          stk_pop;
    logic [PW-1:0] stk_top;
    logic [LW-1:0] stk_level;
    logic          stk_full;
    logic          stk_empty;
    logic          fault_ev;
    logic [PW-1:0] pc_inc;

    assign pc_inc = pc_q + PW'(1);

    // Flow strobes only act while the registered execEn is high (RUN/STEP).
    // rstPC masks everything; ret masks call.
    assign stk_clr  = exec_en_q && bus.rstPC;
    assign stk_pop  = exec_en_q && !bus.rstPC && bus.ret && !stk_empty;
    assign stk_push = exec_en_q && !bus.rstPC && !bus.ret && bus.call && !stk_full;
    assign fault_ev = exec_en_q && !bus.rstPC &&
                      ((bus.ret && stk_empty) || (!bus.ret && bus.call && stk_full));

    seq_stack #(
        .W     (PW),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .clr   (stk_clr),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .level (stk_level),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next PC with priority rstPC > ret > call > wrJumpAdr > cePC > hold.
    // A faulting ret/call leaves the PC where it is.
    always_comb begin
        pc_d = pc_q;
        if (exec_en_q) begin
            if (bus.rstPC) begin
                pc_d = RV;
            end else if (bus.ret) begin
                if (!stk_empty) pc_d = stk_top;
            end else if (bus.call) begin
                if (!stk_full) pc_d = bus.jumpAdr;
            end else if (bus.wrJumpAdr) begin
                pc_d = bus.jumpAdr;
            end else if (bus.cePC) begin
                pc_d = pc_inc;
            end
        end
    end

    // Control FSM; execEn/halted are registered from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RV;
            exec_en_q <= 1'b1;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (fault_ev) begin
                fault_q <= 1'b1;
            end
            case (state_q)
                RUN, STEP: begin
                    if (fault_ev) begin
                        state_q   <= FAULT;
                        exec_en_q <= 1'b0;
                        halted_q  <= 1'b0;
                    end else if (bus.dbgHalt) begin
                        state_q   <= HALT;
                        exec_en_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end else begin
                        state_q   <= RUN;
                        exec_en_q <= 1'b1;
                        halted_q  <= 1'b0;
                    end
                end
                HALT: begin
                    if (!bus.dbgHalt) begin
                        state_q   <= RUN;
                        exec_en_q <= 1'b1;
                        halted_q  <= 1'b0;
                    end else if (bus.dbgStep) begin
                        state_q   <= STEP;
                        exec_en_q <= 1'b1;
                        halted_q  <= 1'b0;
                    end else begin
                        state_q   <= HALT;
                        exec_en_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= FAULT;
                    exec_en_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.adrProgMem = pc_q;
    assign bus.execEn     = exec_en_q;
    assign bus.halted     = halted_q;
    assign bus.stackFault = fault_q;
    assign bus.stackLevel = stk_level;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: stimulus queues expected outputs,
// a monitor pops one entry after each clock edge and compares.
module tb_prog_sequencer;

    localparam int RP = 1;
    localparam int CE = 2;
    localparam int WJ = 4;
    localparam int CL = 8;
    localparam int RT = 16;
    localparam int DH = 32;
    localparam int DS = 64;

    typedef struct {
        string      nm;
        logic [7:0] pc;
        logic       en;
        logic       h;
        logic       f;
        logic [3:0] lv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    prog_sequencer_if #(.PML(8), .LW(4)) bus ();

    prog_sequencer #(
        .prog_mem_length (8),
        .STACK_DEPTH     (8),
        .RESET_VEC       (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic set_in(input int fl, input logic [7:0] ja);
        bus.rstPC     = (fl & RP) != 0;
        bus.cePC      = (fl & CE) != 0;
        bus.wrJumpAdr = (fl & WJ) != 0;
        bus.call      = (fl & CL) != 0;
        bus.ret       = (fl & RT) != 0;
        bus.dbgHalt   = (fl & DH) != 0;
        bus.dbgStep   = (fl & DS) != 0;
        bus.jumpAdr   = ja;
    endtask

    // One cycle of stimulus plus the outputs expected after the next edge.
    task automatic drive(input string nm, input int fl, input logic [7:0] ja,
                         input logic [7:0] epc, input logic een, input logic eh,
                         input logic ef, input logic [3:0] elv);
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        set_in(fl, ja);
        e.nm = nm; e.pc = epc; e.en = een; e.h = eh; e.f = ef; e.lv = elv;
        sb.push_back(e);
    endtask

    task automatic do_reset(input string nm);
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 8'h00);
        e.nm = nm; e.pc = 8'h00; e.en = 1'b1; e.h = 1'b0; e.f = 1'b0; e.lv = 4'd0;
        sb.push_back(e);
    endtask

    // Monitor: the DUT presents a new output word every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (bus.adrProgMem !== e.pc || bus.execEn !== e.en ||
                    bus.halted !== e.h || bus.stackFault !== e.f ||
                    bus.stackLevel !== e.lv) begin
                    failed++;
                    $display("FAIL %s: got pc=%h en=%b halted=%b fault=%b lvl=%0d, want pc=%h en=%b halted=%b fault=%b lvl=%0d",
                             e.nm, bus.adrProgMem, bus.execEn, bus.halted, bus.stackFault,
                             bus.stackLevel, e.pc, e.en, e.h, e.f, e.lv);
                end else begin
                    $display("[TB] ok %s pc=%h en=%b halted=%b fault=%b lvl=%0d",
                             e.nm, bus.adrProgMem, bus.execEn, bus.halted,
                             bus.stackFault, bus.stackLevel);
                end
            end
        end
    end

    initial begin
        set_in(0, 8'h00);
        do_reset("reset");

        // Linear fetch with wrap past 0xFF.
        for (int i = 1; i <= 258; i++) begin
            drive("inc", CE, 8'h00, 8'(i), 1, 0, 0, 0);
        end

        // Jumps; wrJumpAdr outranks cePC.
        drive("jmp10", WJ, 8'h10, 8'h10, 1, 0, 0, 0);
        drive("jmp40", WJ | CE, 8'h40, 8'h40, 1, 0, 0, 0);
        drive("jmp05", WJ, 8'h05, 8'h05, 1, 0, 0, 0);

        // Call / return.
        drive("call80", CL, 8'h80, 8'h80, 1, 0, 0, 1);
        drive("inc81", CE, 8'h00, 8'h81, 1, 0, 0, 1);
        drive("inc82", CE, 8'h00, 8'h82, 1, 0, 0, 1);
        drive("inc83", CE, 8'h00, 8'h83, 1, 0, 0, 1);
        drive("ret06", RT, 8'h00, 8'h06, 1, 0, 0, 0);
        drive("call90", CL, 8'h90, 8'h90, 1, 0, 0, 1);
        drive("callret", CL | RT, 8'hAA, 8'h07, 1, 0, 0, 0);

        // Halt / single step.
        drive("jmp30", WJ, 8'h30, 8'h30, 1, 0, 0, 0);
        drive("haltreq", CE | DH, 8'h00, 8'h31, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive("haltce", CE | DH, 8'h00, 8'h31, 0, 1, 0, 0);
        end
        drive("stepin", CE | DH | DS, 8'h00, 8'h31, 1, 0, 0, 0);
        drive("stepex", CE | DH, 8'h00, 8'h32, 0, 1, 0, 0);
        drive("resume", 0, 8'h00, 8'h32, 1, 0, 0, 0);
        drive("inc33", CE, 8'h00, 8'h33, 1, 0, 0, 0);
        drive("steprun", CE | DS, 8'h00, 8'h34, 1, 0, 0, 0);

        // rstPC beats cePC and empties the stack.
        drive("call50", CL, 8'h50, 8'h50, 1, 0, 0, 1);
        drive("rstpc", RP | CE, 8'h00, 8'h00, 1, 0, 0, 0);
        drive("jmp60", WJ | CE, 8'h60, 8'h60, 1, 0, 0, 0);
        drive("halt2", DH, 8'h00, 8'h60, 0, 1, 0, 0);
        drive("callhlt", CL | DH, 8'h77, 8'h60, 0, 1, 0, 0);
        do_reset("rsthalt");

        // Overflow on the ninth call.
        for (int k = 1; k <= 8; k++) begin
            drive("callN", CL, 8'(8'h10 + k), 8'(8'h10 + k), 1, 0, 0, 4'(k));
        end
        drive("call9", CL, 8'hF0, 8'h18, 0, 0, 1, 8);
        drive("ovfce", CE, 8'h00, 8'h18, 0, 0, 1, 8);
        do_reset("rstovf");

        // Underflow.
        drive("jmp20", WJ, 8'h20, 8'h20, 1, 0, 0, 0);
        drive("retemp", RT, 8'h00, 8'h20, 0, 0, 1, 0);
        drive("unfce", CE, 8'h00, 8'h20, 0, 0, 1, 0);
        do_reset("rstunf");

        // Fault taken during a single step.
        drive("jmp22", WJ, 8'h22, 8'h22, 1, 0, 0, 0);
        drive("halt3", DH, 8'h00, 8'h22, 0, 1, 0, 0);
        drive("step3", DH | DS, 8'h00, 8'h22, 1, 0, 0, 0);
        drive("stepret", RT | DH, 8'h00, 8'h22, 0, 0, 1, 0);
        do_reset("rstend");

        @(negedge clk);
        set_in(0, 8'h00);
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expected entries never checked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
